// File: rtl/rob_except_collector_pkg.sv
// Shared types for ROB exception collection: ROB age tags, exception report record, collector states.
// rob_older() is the single source of truth for ROB age ordering across wrap.
package rob_except_collector_pkg;

  localparam int XLEN      = 64;
  localparam int ROB_IDX_W = 7;
  localparam int CAUSE_W   = 16;

  typedef struct packed {
    logic                 flipped;
    logic [ROB_IDX_W-1:0] idx;
  } robIdx_t;

  typedef struct packed {
    robIdx_t            robIdx;
    logic [CAUSE_W-1:0] cause;
    logic [XLEN-1:0]    tval;
  } except_rpt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    TRAP = 2'd2
  } except_state_e;

  // a is strictly older than b; equal tags are never older
  function automatic logic rob_older(robIdx_t a, robIdx_t b);
    if (a.flipped == b.flipped) return a.idx < b.idx;
    return a.idx > b.idx;
  endfunction

endpackage

// File: rtl/rob_except_collector_if.sv
// Report/head/squash/trap bundle between writeback, ROB and the trap unit.
// IRQ inject lines exist only when EXCEPT_IRQ_INJECT_EN is defined.
interface rob_except_collector_if #(
  parameter int NUM_SRC = 3,
  parameter int TVAL_W  = rob_except_collector_pkg::XLEN
);
  import rob_except_collector_pkg::*;

  logic [NUM_SRC-1:0] i_rpt_vld;
  robIdx_t            i_rpt_robIdx [NUM_SRC];
  logic [CAUSE_W-1:0] i_rpt_cause  [NUM_SRC];
  logic [TVAL_W-1:0]  i_rpt_tval   [NUM_SRC];
  logic               i_head_vld;
  robIdx_t            i_head_robIdx;
  logic               i_squash_vld;
  robIdx_t            i_squash_robIdx;
  logic               i_flush;
  logic               i_trap_ack;
`ifdef EXCEPT_IRQ_INJECT_EN
  logic               i_irq_vld;
  logic [CAUSE_W-1:0] i_irq_cause;
`endif
  logic               o_trap_vld;
  robIdx_t            o_trap_robIdx;
  logic [CAUSE_W-1:0] o_trap_cause;
  logic               o_trap_is_irq;
  logic [TVAL_W-1:0]  o_trap_tval;
  logic               o_pending;

  modport master (
    output i_rpt_vld, i_rpt_robIdx, i_rpt_cause, i_rpt_tval,
    output i_head_vld, i_head_robIdx, i_squash_vld, i_squash_robIdx,
    output i_flush, i_trap_ack,
`ifdef EXCEPT_IRQ_INJECT_EN
    output i_irq_vld, i_irq_cause,
`endif
    input  o_trap_vld, o_trap_robIdx, o_trap_cause, o_trap_is_irq,
    input  o_trap_tval, o_pending
  );

  modport slave (
    input  i_rpt_vld, i_rpt_robIdx, i_rpt_cause, i_rpt_tval,
    input  i_head_vld, i_head_robIdx, i_squash_vld, i_squash_robIdx,
    input  i_flush, i_trap_ack,
`ifdef EXCEPT_IRQ_INJECT_EN
    input  i_irq_vld, i_irq_cause,
`endif
    output o_trap_vld, o_trap_robIdx, o_trap_cause, o_trap_is_irq,
    output o_trap_tval, o_pending
  );

endinterface

// File: rtl/rob_except_collector_oldest_sel.sv
// Combinational NUM_SRC-way oldest-tag picker built on rob_older; lowest port wins age ties.
// Generic over the payload: it returns only the winning port, so LSQ age picking can reuse it.
module except_oldest_sel
  import rob_except_collector_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] vld_i,
  input  robIdx_t            idx_i [NUM_SRC],
  output logic               sel_vld_o,
  output logic [SEL_W-1:0]   sel_o
);

  robIdx_t best;

  // NOTE: every output and temporary gets a default before the loop, so no path can infer a latch.
  always_comb begin
    sel_vld_o = 1'b0;
    sel_o     = '0;
    best      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // strict compare keeps the earlier (lower) port on a tie
      if (vld_i[i] && (!sel_vld_o || rob_older(idx_i[i], best))) begin
        sel_vld_o = 1'b1;
        sel_o     = SEL_W'(i);
        best      = idx_i[i];
      end
    end
  end

endmodule

// File: rtl/rob_except_collector.sv
// Holds the oldest pending exception and raises one trap when it reaches the ROB head.
// Optional macro EXCEPT_IRQ_INJECT_EN adds interrupt injection at an idle ROB head.
module rob_except_collector
  import rob_except_collector_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int TVAL_W  = XLEN
) (
  input logic clk,
  input logic rst,
  rob_except_collector_if.slave bus
);

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  except_state_e      state_q, state_d;
  except_rpt_t        held_q, held_d;
  logic [NUM_SRC-1:0] rpt_live;
  logic               sel_vld;
  logic [SEL_W-1:0]   sel;
  except_rpt_t        new_rpt;
  logic               held_live;
`ifdef EXCEPT_IRQ_INJECT_EN
  logic               irq_q, irq_d;
`endif

  // Reports strictly younger than a same-cycle squash point never existed.
  always_comb begin
    rpt_live = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rpt_live[i] = bus.i_rpt_vld[i] &&
                    !(bus.i_squash_vld && rob_older(bus.i_squash_robIdx, bus.i_rpt_robIdx[i]));
    end
  end

  except_oldest_sel #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_sel (
    .vld_i     (rpt_live),
    .idx_i     (bus.i_rpt_robIdx),
    .sel_vld_o (sel_vld),
    .sel_o     (sel)
  );

  always_comb begin
    new_rpt.robIdx = bus.i_rpt_robIdx[sel];
    new_rpt.cause  = bus.i_rpt_cause[sel];
    new_rpt.tval   = XLEN'(bus.i_rpt_tval[sel]);
  end

  // NOTE: the held entry is reset along with the state so o_trap_* read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      held_q  <= '0;
`ifdef EXCEPT_IRQ_INJECT_EN
      irq_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      held_q  <= held_d;
`ifdef EXCEPT_IRQ_INJECT_EN
      irq_q   <= irq_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
`ifdef EXCEPT_IRQ_INJECT_EN
    irq_d     = irq_q;
`endif
    held_live = (state_q == PEND) &&
                !(bus.i_squash_vld && rob_older(bus.i_squash_robIdx, held_q.robIdx));
    if (bus.i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, PEND: begin
          if (held_live) begin
            if (sel_vld && rob_older(new_rpt.robIdx, held_q.robIdx)) begin
              held_d = new_rpt;
            end else if (bus.i_head_vld && (bus.i_head_robIdx == held_q.robIdx)) begin
              state_d = TRAP;
            end
          end else if (sel_vld) begin
            held_d  = new_rpt;
            state_d = PEND;
`ifdef EXCEPT_IRQ_INJECT_EN
            irq_d   = 1'b0;
          end else if ((state_q == IDLE) && bus.i_irq_vld && bus.i_head_vld) begin
            held_d.robIdx = bus.i_head_robIdx;
            held_d.cause  = bus.i_irq_cause;
            held_d.tval   = '0;
            irq_d         = 1'b1;
            state_d       = TRAP;
`endif
          end else begin
            state_d = IDLE;
          end
        end
        TRAP: begin
          if (bus.i_trap_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_trap_vld    = (state_q == TRAP);
    bus.o_pending     = (state_q != IDLE);
    bus.o_trap_robIdx = held_q.robIdx;
    bus.o_trap_cause  = held_q.cause;
    bus.o_trap_tval   = TVAL_W'(held_q.tval);
`ifdef EXCEPT_IRQ_INJECT_EN
    bus.o_trap_is_irq = irq_q;
`else
    bus.o_trap_is_irq = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rob_except_collector.sv
// Directed plan scenarios plus windowed random traffic against an age-distance reference model.
// Define EXCEPT_IRQ_INJECT_EN to also exercise the interrupt injection path.
module tb_rob_except_collector;
  import rob_except_collector_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rob_except_collector_if #(.NUM_SRC(N), .TVAL_W(64)) bus ();

  rob_except_collector #(.NUM_SRC(N), .TVAL_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] s_vld;
  logic [7:0]   s_idx   [N];
  logic [15:0]  s_cause [N];
  logic [63:0]  s_tval  [N];
  logic         s_head_vld, s_sq_vld, s_flush, s_ack, s_irq;
  logic [7:0]   s_head, s_sq;
  logic [15:0]  s_irq_cause;

  bit           m_pend, m_trap, m_irq;
  logic [7:0]   m_idx;
  logic [15:0]  m_cause;
  logic [63:0]  m_tval;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Age as ring distance: a is older than b when b sits 1..127 slots ahead of a.
  function automatic bit older(logic [7:0] a, logic [7:0] b);
    logic [7:0] d;
    d = b - a;
    return (d != 8'd0) && (d < 8'd128);
  endfunction

  function automatic bit survives(int i);
    return s_vld[i] && !(s_sq_vld && older(s_sq, s_idx[i]));
  endfunction

  task automatic idle_inputs();
    s_vld = '0; s_head_vld = 0; s_sq_vld = 0; s_flush = 0; s_ack = 0; s_irq = 0;
    s_head = '0; s_sq = '0; s_irq_cause = '0;
    for (int i = 0; i < N; i++) begin
      s_idx[i] = '0; s_cause[i] = '0; s_tval[i] = '0;
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_trap = 0; m_irq = 0; m_idx = '0; m_cause = '0; m_tval = '0;
  endtask

  task automatic model_step();
    int  win;
    bit  was_idle;
    win = -1;
    was_idle = !m_pend;
    if (s_flush) begin
      m_pend = 0; m_trap = 0;
      return;
    end
    if (m_trap) begin
      if (s_ack) begin m_trap = 0; m_pend = 0; end
      return;
    end
    // winner: first surviving port that no other survivor beats on age
    for (int i = 0; i < N; i++) begin
      if (survives(i) && win < 0) begin
        bit beaten;
        beaten = 0;
        for (int j = 0; j < N; j++)
          if (survives(j) && older(s_idx[j], s_idx[i])) beaten = 1;
        if (!beaten) win = i;
      end
    end
    if (m_pend && s_sq_vld && older(s_sq, m_idx)) m_pend = 0;
    if (m_pend) begin
      if (win >= 0 && older(s_idx[win], m_idx)) begin
        m_idx = s_idx[win]; m_cause = s_cause[win]; m_tval = s_tval[win];
      end else if (s_head_vld && s_head == m_idx) begin
        m_trap = 1;
      end
    end else if (win >= 0) begin
      m_idx = s_idx[win]; m_cause = s_cause[win]; m_tval = s_tval[win];
      m_pend = 1; m_irq = 0;
`ifdef EXCEPT_IRQ_INJECT_EN
    end else if (was_idle && s_irq && s_head_vld) begin
      m_idx = s_head; m_cause = s_irq_cause; m_tval = '0;
      m_pend = 1; m_trap = 1; m_irq = 1;
`endif
    end
  endtask

  task automatic cycle(string tag);
    for (int i = 0; i < N; i++) begin
      bus.i_rpt_robIdx[i] = s_idx[i];
      bus.i_rpt_cause[i]  = s_cause[i];
      bus.i_rpt_tval[i]   = s_tval[i];
    end
    bus.i_rpt_vld       = s_vld;
    bus.i_head_vld      = s_head_vld;
    bus.i_head_robIdx   = s_head;
    bus.i_squash_vld    = s_sq_vld;
    bus.i_squash_robIdx = s_sq;
    bus.i_flush         = s_flush;
    bus.i_trap_ack      = s_ack;
`ifdef EXCEPT_IRQ_INJECT_EN
    bus.i_irq_vld       = s_irq;
    bus.i_irq_cause     = s_irq_cause;
`endif
    model_step();
    @(posedge clk);
    #1;
    check({tag, "_trap_vld"}, 64'(bus.o_trap_vld), 64'(m_trap));
    check({tag, "_pending"},  64'(bus.o_pending), 64'(m_pend || m_trap));
    check({tag, "_is_irq"},   64'(bus.o_trap_is_irq), 64'(m_trap && m_irq));
    if (m_pend || m_trap) begin
      check({tag, "_robidx"}, 64'(bus.o_trap_robIdx), 64'(m_idx));
      check({tag, "_cause"},  64'(bus.o_trap_cause), 64'(m_cause));
      check({tag, "_tval"},   bus.o_trap_tval, m_tval);
    end
  endtask

  task automatic report(int port, logic [7:0] idx, logic [15:0] cause);
    s_vld[port]   = 1'b1;
    s_idx[port]   = idx;
    s_cause[port] = cause;
    s_tval[port]  = {48'h0bad_f00d_0000, idx, 8'(cause)};
  endtask

  task automatic flush_cycle(string tag);
    idle_inputs(); s_flush = 1; cycle(tag); idle_inputs();
  endtask

  initial begin
    logic [7:0] base;
    idle_inputs();
    model_reset();
    cycle_inputs_at_reset();
    #12;
    check("reset_trap_vld", 64'(bus.o_trap_vld), 64'd0);
    check("reset_pending",  64'(bus.o_pending), 64'd0);
    check("reset_robidx",   64'(bus.o_trap_robIdx), 64'd0);
    check("reset_cause",    64'(bus.o_trap_cause), 64'd0);
    check("reset_tval",     bus.o_trap_tval, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Plan 1: capture, head match, one-cycle latency, hold until ack
    report(0, 8'h05, 16'd5); cycle("t1_cap");
    check("t1_pend_no_trap", 64'(bus.o_trap_vld), 64'd0);
    idle_inputs(); s_head_vld = 1; s_head = 8'h05; cycle("t1_head");
    check("t1_trap_cause", 64'(bus.o_trap_cause), 64'd5);
    idle_inputs(); cycle("t1_hold");
    s_ack = 1; cycle("t1_ack");
    check("t1_after_ack", 64'(bus.o_pending), 64'd0);

    // Plan 2: same-cycle oldest pick, younger later report ignored
    idle_inputs(); report(1, 8'h09, 16'd7); report(2, 8'h03, 16'd2); cycle("t2_pick");
    check("t2_idx", 64'(bus.o_trap_robIdx), 64'h03);
    check("t2_cause", 64'(bus.o_trap_cause), 64'd2);
    idle_inputs(); report(0, 8'h04, 16'd13); cycle("t2_ignore");
    check("t2_kept", 64'(bus.o_trap_robIdx), 64'h03);
    flush_cycle("t2_flush");

    // Plan 3: wrap-around ages
    report(0, 8'd120, 16'd5); cycle("t3a_cap");
    idle_inputs(); report(1, 8'h82, 16'd7); cycle("t3a_new");
    check("t3a_kept", 64'(bus.o_trap_robIdx), 64'd120);
    flush_cycle("t3_flush");
    report(0, 8'h82, 16'd7); cycle("t3b_cap");
    idle_inputs(); report(2, 8'd120, 16'd5); cycle("t3b_new");
    check("t3b_replaced", 64'(bus.o_trap_robIdx), 64'd120);
    flush_cycle("t3b_flush");

    // Plan 4: squash kills only a younger held entry
    report(0, 8'd20, 16'd4); cycle("t4_cap");
    idle_inputs(); s_sq_vld = 1; s_sq = 8'd30; cycle("t4_sq_keep");
    check("t4_kept", 64'(bus.o_pending), 64'd1);
    s_sq = 8'd10; cycle("t4_sq_kill");
    check("t4_killed", 64'(bus.o_pending), 64'd0);
    idle_inputs();

    // Plan 5: flush beats ack; async reset mid-trap
    report(0, 8'h11, 16'd6); cycle("t5_cap");
    idle_inputs(); s_head_vld = 1; s_head = 8'h11; cycle("t5_trap");
    idle_inputs(); s_flush = 1; s_ack = 1; cycle("t5_flush_ack");
    check("t5_no_trap", 64'(bus.o_trap_vld), 64'd0);
    idle_inputs(); report(0, 8'h12, 16'd1); cycle("t5_cap2");
    idle_inputs(); s_head_vld = 1; s_head = 8'h12; cycle("t5_trap2");
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check("t5_rst_vld", 64'(bus.o_trap_vld), 64'd0);
    check("t5_rst_pend", 64'(bus.o_pending), 64'd0);
    check("t5_rst_idx", 64'(bus.o_trap_robIdx), 64'd0);
    check("t5_rst_tval", bus.o_trap_tval, 64'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

`ifdef EXCEPT_IRQ_INJECT_EN
    // Plan 6: interrupt at idle head; pending exception wins over irq
    idle_inputs(); s_head_vld = 1; s_head = 8'h07; s_irq = 1; s_irq_cause = 16'd7; cycle("t6_irq");
    check("t6_is_irq", 64'(bus.o_trap_is_irq), 64'd1);
    check("t6_tval", bus.o_trap_tval, 64'd0);
    idle_inputs(); s_ack = 1; cycle("t6_ack");
    idle_inputs(); report(0, 8'h07, 16'd5); cycle("t6_cap");
    idle_inputs(); s_head_vld = 1; s_head = 8'h07; s_irq = 1; s_irq_cause = 16'd7; cycle("t6_exc");
    check("t6_exc_irq", 64'(bus.o_trap_is_irq), 64'd0);
    check("t6_exc_cause", 64'(bus.o_trap_cause), 64'd5);
    idle_inputs(); s_ack = 1; cycle("t6_ack2");
    idle_inputs();
`endif

    // Random traffic kept inside a <128-slot window so ages form a total order
    base = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 249) begin
        flush_cycle("rnd_rebase");
        base = base + 8'($urandom_range(20, 90));
      end else begin
        idle_inputs();
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 3) == 0) report(i, base + 8'($urandom_range(0, 40)), 16'($urandom_range(0, 15)));
        s_head_vld = ($urandom_range(0, 9) < 6);
        s_head = (m_pend && $urandom_range(0, 1) == 1) ? m_idx : base + 8'($urandom_range(0, 40));
        s_sq_vld = ($urandom_range(0, 9) == 0);
        s_sq = base + 8'($urandom_range(0, 40));
        s_flush = ($urandom_range(0, 99) < 3);
        s_ack = ($urandom_range(0, 9) < 4);
        cycle("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic cycle_inputs_at_reset();
    bus.i_rpt_vld = '0;
    for (int i = 0; i < N; i++) begin
      bus.i_rpt_robIdx[i] = '0; bus.i_rpt_cause[i] = '0; bus.i_rpt_tval[i] = '0;
    end
    bus.i_head_vld = 0; bus.i_head_robIdx = '0; bus.i_squash_vld = 0; bus.i_squash_robIdx = '0;
    bus.i_flush = 0; bus.i_trap_ack = 0;
`ifdef EXCEPT_IRQ_INJECT_EN
    bus.i_irq_vld = 0; bus.i_irq_cause = '0;
`endif
  endtask

endmodule
